cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: resets a controlled CPU, lets it run until it halts
// or a cycle budget runs out, and records cycle count and LED activity.
module cpu_run_ctrl #(
    parameter int LED_W      = 4,
    parameter int RST_HOLD   = 2,
    parameter int MAX_CYCLES = 80,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn_ini,
    input  logic             start,
    input  logic             cpu_stop,
    input  logic [LED_W-1:0] cpu_leds,
    output logic             cpu_rstn,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles,
    output logic [LED_W-1:0] leds_last,
    output logic [7:0]       led_changes
);

    localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CYC_MAX   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nx;
    logic [HOLD_W-1:0]  r_hold, w_hold_nx;
    logic [CNT_W-1:0]   r_cycles, w_cycles_nx, w_cyc_inc;
    logic               r_timeout, w_timeout_nx;
    logic [LED_W-1:0]   r_leds_last, w_leds_last_nx;
    logic [7:0]         r_changes, w_changes_nx;
    logic               r_cpu_rstn, r_running, r_done;

    // Next-state and next-result computation for all registered state.
    always_comb begin
        w_state_nx     = r_state;
        w_hold_nx      = r_hold;
        w_cycles_nx    = r_cycles;
        w_timeout_nx   = r_timeout;
        w_leds_last_nx = r_leds_last;
        w_changes_nx   = r_changes;
        w_cyc_inc      = r_cycles + CNT_W'(1);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // New run: drop every result of the previous one.
                    w_state_nx     = S_RESET;
                    w_hold_nx      = '0;
                    w_cycles_nx    = '0;
                    w_timeout_nx   = 1'b0;
                    w_leds_last_nx = '0;
                    w_changes_nx   = 8'd0;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_RESET: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_hold_nx = r_hold + HOLD_W'(1);
                end
            end
            S_RUN: begin
                // LEDs are captured on every RUN edge, the exit edge included.
                w_leds_last_nx = cpu_leds;
                if ((cpu_leds != r_leds_last) && (r_changes != 8'd255)) begin
                    w_changes_nx = r_changes + 8'd1;
                end else begin
                    w_changes_nx = r_changes;
                end
                // A halt takes priority over budget expiry on the same edge.
                if (cpu_stop) begin
                    w_state_nx   = S_DONE;
                    w_timeout_nx = 1'b0;
                end else begin
                    w_cycles_nx = w_cyc_inc;
                    if (w_cyc_inc == CYC_MAX) begin
                        w_state_nx   = S_DONE;
                        w_timeout_nx = 1'b1;
                    end else begin
                        w_state_nx = S_RUN;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn_ini) begin
        if (!rstn_ini) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Result and status registers; status flags follow the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rstn_ini) begin
        if (!rstn_ini) begin
            r_hold      <= '0;
            r_cycles    <= '0;
            r_timeout   <= 1'b0;
            r_leds_last <= '0;
            r_changes   <= 8'd0;
            r_cpu_rstn  <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_hold      <= w_hold_nx;
            r_cycles    <= w_cycles_nx;
            r_timeout   <= w_timeout_nx;
            r_leds_last <= w_leds_last_nx;
            r_changes   <= w_changes_nx;
            r_cpu_rstn  <= (w_state_nx == S_RUN) || (w_state_nx == S_DONE);
            r_running   <= (w_state_nx == S_RUN);
            r_done      <= (w_state_nx == S_DONE);
        end
    end

    assign cpu_rstn    = r_cpu_rstn;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycles      = r_cycles;
    assign leds_last   = r_leds_last;
    assign led_changes = r_changes;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a vector table for the basic run plus
// hand-written sequences for budget, stop race, LED saturation and reset abort.
module tb_cpu_run_ctrl;

    logic clk;
    logic rstn_ini;

    // Instance A: default parameters
    logic        a_start, a_stop;
    logic [3:0]  a_leds;
    logic        a_rstn, a_run, a_done, a_to;
    logic [15:0] a_cyc;
    logic [3:0]  a_last;
    logic [7:0]  a_chg;

    // Instance B: LED_W=8, RST_HOLD=5, larger budget for saturation test
    logic        b_start, b_stop;
    logic [7:0]  b_leds;
    logic        b_rstn, b_run, b_done, b_to;
    logic [15:0] b_cyc;
    logic [7:0]  b_last;
    logic [7:0]  b_chg;

    int n_checks = 0;
    int n_errors = 0;

    cpu_run_ctrl u_a (
        .clk(clk), .rstn_ini(rstn_ini), .start(a_start), .cpu_stop(a_stop),
        .cpu_leds(a_leds), .cpu_rstn(a_rstn), .running(a_run), .done(a_done),
        .timeout(a_to), .cycles(a_cyc), .leds_last(a_last), .led_changes(a_chg)
    );

    cpu_run_ctrl #(.LED_W(8), .RST_HOLD(5), .MAX_CYCLES(400), .CNT_W(16)) u_b (
        .clk(clk), .rstn_ini(rstn_ini), .start(b_start), .cpu_stop(b_stop),
        .cpu_leds(b_leds), .cpu_rstn(b_rstn), .running(b_run), .done(b_done),
        .timeout(b_to), .cycles(b_cyc), .leds_last(b_last), .led_changes(b_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        start;
        logic        stop;
        logic [3:0]  leds;
        logic        e_rstn;
        logic        e_run;
        logic        e_done;
        logic        e_to;
        logic [15:0] e_cyc;
        logic [3:0]  e_last;
        logic [7:0]  e_chg;
    } vec_t;

    vec_t tbl [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic rstn, input logic run, input logic dn,
                         input logic to, input logic [15:0] cyc, input logic [3:0] last,
                         input logic [7:0] chg);
        chk({tag, ".cpu_rstn"},    32'(a_rstn), 32'(rstn));
        chk({tag, ".running"},     32'(a_run),  32'(run));
        chk({tag, ".done"},        32'(a_done), 32'(dn));
        chk({tag, ".timeout"},     32'(a_to),   32'(to));
        chk({tag, ".cycles"},      32'(a_cyc),  32'(cyc));
        chk({tag, ".leds_last"},   32'(a_last), 32'(last));
        chk({tag, ".led_changes"}, 32'(a_chg),  32'(chg));
    endtask

    initial begin
        //            st    sp    leds   rstn  run   done  to    cyc     last   chg
        tbl[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 4'd0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 4'd1, 8'd1};
        tbl[5]  = '{1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 4'd2, 8'd2};
        tbl[6]  = '{1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 4'd2, 8'd2};
        tbl[7]  = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 4'd3, 8'd3};
        tbl[8]  = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6, 4'd3, 8'd3};
        tbl[9]  = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 4'd3, 8'd3};
        tbl[10] = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd8, 4'd3, 8'd3};
        tbl[11] = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd9, 4'd3, 8'd3};
        tbl[12] = '{1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9, 4'd3, 8'd3};
        tbl[13] = '{1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9, 4'd3, 8'd3};
        tbl[14] = '{1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9, 4'd3, 8'd3};

        rstn_ini = 1'b0;
        a_start = 1'b0; a_stop = 1'b0; a_leds = 4'd0;
        b_start = 1'b0; b_stop = 1'b0; b_leds = 8'd0;
        tick();
        tick();
        chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0);
        chk("reset.b_rstn", 32'(b_rstn), 32'd0);
        rstn_ini = 1'b1;
        tick();
        tick();
        chk_a("idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0);

        // Basic run: two RESET cycles, LED stepping, stop on 10th RUN cycle
        for (int i = 0; i < 15; i++) begin
            a_start = tbl[i].start;
            a_stop  = tbl[i].stop;
            a_leds  = tbl[i].leds;
            tick();
            chk_a($sformatf("vec%0d", i), tbl[i].e_rstn, tbl[i].e_run, tbl[i].e_done,
                  tbl[i].e_to, tbl[i].e_cyc, tbl[i].e_last, tbl[i].e_chg);
        end
        a_leds = 4'd0;

        // Budget exhaustion: restart from DONE, cpu_stop held low
        a_start = 1'b1; tick(); a_start = 1'b0;
        tick(); tick();
        chk_a("to.run0", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0);
        for (int i = 0; i < 79; i++) tick();
        chk_a("to.c79", 1'b1, 1'b1, 1'b0, 1'b0, 16'd79, 4'd0, 8'd0);
        tick();
        chk_a("to.c80", 1'b1, 1'b0, 1'b1, 1'b1, 16'd80, 4'd0, 8'd0);

        // Restart after timeout clears results; stop on the expiring edge wins
        a_leds = 4'd7;
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk_a("race.reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0);
        tick(); tick();
        for (int i = 0; i < 79; i++) tick();
        chk_a("race.c79", 1'b1, 1'b1, 1'b0, 1'b0, 16'd79, 4'd7, 8'd1);
        a_stop = 1'b1; tick(); a_stop = 1'b0;
        chk_a("race.stop", 1'b1, 1'b0, 1'b1, 1'b0, 16'd79, 4'd7, 8'd1);

        // Asynchronous reset in RUN at cycles=40
        a_leds = 4'd9;
        a_start = 1'b1; tick(); a_start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 40; i++) tick();
        chk_a("abort.c40", 1'b1, 1'b1, 1'b0, 1'b0, 16'd40, 4'd9, 8'd1);
        #2 rstn_ini = 1'b0;
        #1;
        chk_a("abort.async", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0);
        tick();
        rstn_ini = 1'b1;
        tick(); tick(); tick();
        chk_a("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 8'd0);
        a_start = 1'b1; tick(); a_start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) tick();
        a_stop = 1'b1; tick(); a_stop = 1'b0;
        chk_a("fresh.stop", 1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 4'd9, 8'd1);

        // Instance B: five-cycle CPU reset, then LED-change saturation
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("b.hold1", 32'(b_rstn), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("b.hold5", 32'(b_rstn), 32'd0);
        tick();
        chk("b.run_rstn", 32'(b_rstn), 32'd1);
        chk("b.running", 32'(b_run), 32'd1);
        for (int i = 0; i < 300; i++) begin
            b_leds = (i % 2 == 1) ? 8'h5A : 8'hA5;
            tick();
            if (i == 254) chk("b.chg255", 32'(b_chg), 32'd255);
        end
        chk("b.chg_sat", 32'(b_chg), 32'd255);
        chk("b.cyc300", 32'(b_cyc), 32'd300);
        b_stop = 1'b1; tick(); b_stop = 1'b0;
        chk("b.done", 32'(b_done), 32'd1);
        chk("b.last", 32'(b_last), 32'h5A);
        chk("b.chg_held", 32'(b_chg), 32'd255);

        // Instance B second run, independent of the first; exit edge captures LEDs
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("b2.cyc_clr", 32'(b_cyc), 32'd0);
        chk("b2.chg_clr", 32'(b_chg), 32'd0);
        chk("b2.last_clr", 32'(b_last), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        b_leds = 8'h11;
        for (int i = 0; i < 3; i++) tick();
        b_leds = 8'h22; b_stop = 1'b1; tick(); b_stop = 1'b0;
        chk("b2.done", 32'(b_done), 32'd1);
        chk("b2.to", 32'(b_to), 32'd0);
        chk("b2.cyc", 32'(b_cyc), 32'd3);
        chk("b2.last", 32'(b_last), 32'h22);
        chk("b2.chg", 32'(b_chg), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
